// File: rtl/shift_rotate_seq.sv
// shift_rotate_seq: multi-cycle barrel-free shifter/rotator.
// One bit position is moved per clock, so an amount of N costs N cycles in RUN.
// The result register o only updates when the operation completes.
module shift_rotate_seq #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic             inv,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] i0,
  output logic [WIDTH-1:0] o,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_SHL = 2'b00;
  localparam logic [1:0] OP_SHR = 2'b01;
  localparam logic [1:0] OP_ROL = 2'b10;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       eop_q, eop_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic [WIDTH-1:0] step_val;

  // Single-position move of the working value; shifts are logical (zero fill).
  function automatic logic [WIDTH-1:0] step_one(input logic [1:0] eop,
                                                input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] r;
    case (eop)
      OP_SHL:  r = {w[WIDTH-2:0], 1'b0};
      OP_SHR:  r = {1'b0, w[WIDTH-1:1]};
      OP_ROL:  r = {w[WIDTH-2:0], w[WIDTH-1]};
      default: r = {w[0], w[WIDTH-1:1]};
    endcase
    return r;
  endfunction

  // Next step of the working register under the operation fixed at accept time.
  always_comb begin
    step_val = step_one(eop_q, work_q);
  end

  // Next-state logic: accept in IDLE, step in RUN, hold the result in DONE.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    eop_d   = eop_q;
    o_d     = o_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          eop_d = {op[1], op[0] ^ inv};
          if (amt == '0) begin
            o_d     = i0;
            state_d = DONE;
          end else begin
            work_d  = i0;
            cnt_d   = amt;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        work_d = step_val;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == {{(AMT_W-1){1'b0}}, 1'b1}) begin
          o_d     = step_val;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      eop_q   <= '0;
      o_q     <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      eop_q   <= eop_d;
      o_q     <= o_d;
    end
  end

  // Handshake and status outputs are pure decodes of the state register.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    o         = o_q;
  end

endmodule

// File: tb/tb_shift_rotate_seq.sv
// Directed testbench for shift_rotate_seq with hand-computed expected results.
// Inputs change and outputs are sampled on the falling edge.
module tb_shift_rotate_seq;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic        inv;
  logic [3:0]  amt;
  logic [15:0] i0;
  logic [15:0] o;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int checks;
  int errors;

  shift_rotate_seq #(.WIDTH(16), .AMT_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .inv      (inv),
    .amt      (amt),
    .i0       (i0),
    .o        (o),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count a comparison and report it if the observed value is wrong.
  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request from IDLE, wait for the result, check value and latency.
  // Latency counts rising edges from the accepting edge up to the first
  // falling-edge sample that shows out_valid high (amt=0 gives 1).
  // The result is left in DONE; release_result drains it.
  task automatic apply_stimulus(input string tag, input logic [1:0] t_op,
                                input logic t_inv, input logic [3:0] t_amt,
                                input logic [15:0] t_i0, input logic [15:0] exp_o,
                                input int exp_lat);
    int lat;
    logic [15:0] prev_o;
    prev_o = o;
    check_output({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    op        = t_op;
    inv       = t_inv;
    amt       = t_amt;
    i0        = t_i0;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    op       = ~t_op;
    inv      = ~t_inv;
    amt      = ~t_amt;
    i0       = ~t_i0;
    lat = 1;
    if (t_amt != 4'd0) begin
      check_output({tag, "_o_held_in_run"}, {16'd0, o}, {16'd0, prev_o});
    end
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check_output({tag, "_latency"}, lat, exp_lat);
    check_output({tag, "_o"}, {16'd0, o}, {16'd0, exp_o});
  endtask

  // Accept the pending result and confirm the block is back in IDLE.
  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_output({tag, "_out_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check_output({tag, "_in_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  // Main directed sequence.
  initial begin
    int stray;
    logic [15:0] held;
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    op        = 2'b00;
    inv       = 1'b0;
    amt       = 4'd0;
    i0        = 16'd0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    check_output("rst_o", {16'd0, o}, 32'd0);
    check_output("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_output("rst_busy", {31'd0, busy}, 32'd0);

    apply_stimulus("shl4", 2'b00, 1'b0, 4'd4, 16'h55aa, 16'h5aa0, 5);
    release_result("shl4");
    apply_stimulus("rol1", 2'b10, 1'b0, 4'd1, 16'h8001, 16'h0003, 2);
    release_result("rol1");
    apply_stimulus("ror1", 2'b11, 1'b0, 4'd1, 16'h55aa, 16'h2ad5, 2);
    release_result("ror1");
    apply_stimulus("shr_inv15", 2'b01, 1'b1, 4'd15, 16'h0001, 16'h8000, 16);
    release_result("shr_inv15");
    apply_stimulus("shr0", 2'b01, 1'b0, 4'd0, 16'h7fff, 16'h7fff, 1);
    release_result("shr0");
    apply_stimulus("shr3", 2'b01, 1'b0, 4'd3, 16'hf000, 16'h1e00, 4);
    release_result("shr3");
    apply_stimulus("shl_inv8", 2'b00, 1'b1, 4'd8, 16'habcd, 16'h00ab, 9);
    release_result("shl_inv8");
    apply_stimulus("ror_inv15", 2'b11, 1'b1, 4'd15, 16'h0003, 16'h8001, 16);
    release_result("ror_inv15");
    apply_stimulus("shr15", 2'b01, 1'b0, 4'd15, 16'hffff, 16'h0001, 16);
    release_result("shr15");

    // Backpressure: hold DONE for three cycles while a new request is offered.
    apply_stimulus("bp", 2'b10, 1'b0, 4'd2, 16'h4001, 16'h0005, 3);
    held = o;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      op       = 2'b00;
      amt      = 4'd0;
      i0       = 16'hdead;
      @(posedge clk);
      @(negedge clk);
      check_output("bp_o_stable", {16'd0, o}, {16'd0, held});
      check_output("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check_output("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    release_result("bp");
    check_output("bp_not_queued", {16'd0, o}, {16'd0, held});
    check_output("bp_idle_busy", {31'd0, busy}, 32'd0);

    // Reset in the middle of a long rotate aborts it with no result.
    in_valid = 1'b1;
    op       = 2'b10;
    inv      = 1'b0;
    amt      = 4'd8;
    i0       = 16'hffff;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("mid_run_busy", {31'd0, busy}, 32'd1);
    reset    = 1'b0;
    in_valid = 1'b1;
    amt      = 4'd0;
    i0       = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    check_output("rst_run_o", {16'd0, o}, 32'd0);
    check_output("rst_run_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("rst_run_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    check_output("rst_in_valid_ignored", {31'd0, busy}, 32'd0);
    reset    = 1'b1;
    in_valid = 1'b0;
    stray = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid || o != 16'd0) stray++;
    end
    check_output("no_result_after_abort", stray, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_rotate_seq.md
SHIFT_ROTATE_SEQ -- requirements
Module: shift_rotate_seq

Interface
REQ-001 Parameter WIDTH, default 16, datapath width in bits.
REQ-002 Parameter AMT_W, default 4, width of the shift-amount field; max amount 2^AMT_W-1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-005 in_valid  input  1  request present on op/inv/amt/i0.
REQ-006 in_ready  output  1  block able to accept a request.
REQ-007 op  input  2  00 SHL logical, 01 SHR logical, 10 ROL, 11 ROR.
REQ-008 inv  input  1  1 = apply inverse direction (undo): flips op[0] (SHL<->SHR, ROL<->ROR).
REQ-009 amt  input  AMT_W  number of bit positions to move.
REQ-010 i0  input  WIDTH  operand.
REQ-011 o  output  WIDTH  result register.
REQ-012 out_valid  output  1  o holds a completed result.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 busy  output  1  high in RUN or DONE.

Function
REQ-015 FSM states IDLE, RUN, DONE; one state register, encoding free.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 Accept = in_valid & in_ready at an edge; op, inv, amt, i0 captured into internal registers at that edge; later input changes ignored until IDLE re-entered.
REQ-018 Effective op = {op[1], op[0]^inv}, fixed at accept.
REQ-019 Accept with amt != 0: IDLE->RUN, working register loaded with i0, down-counter loaded with amt.
REQ-020 Accept with amt == 0: IDLE->DONE; o = i0 unchanged.
REQ-021 RUN: each cycle moves working register exactly one bit position per effective op and decrements counter; when counter reaches 1 at an edge, the final step is applied and state goes RUN->DONE.
REQ-022 Per-step rules: SHL w<<1 zero-fill LSB; SHR w>>1 zero-fill MSB (logical, no sign extension); ROL {w[WIDTH-2:0],w[WIDTH-1]}; ROR {w[0],w[WIDTH-1:1]}.
REQ-023 Latency: out_valid asserted exactly amt+1 cycles after the accepting edge (amt=0 -> 1 cycle).
REQ-024 DONE: o and out_valid held stable while out_ready=0 (arbitrary backpressure length).
REQ-025 DONE with out_ready=1 at an edge: DONE->IDLE; out_valid deasserts, in_ready asserts in the following cycle; no same-edge re-accept.
REQ-026 o SHALL not change outside the DONE-entry edge and reset; intermediate RUN values are internal only.
REQ-027 in_valid while busy SHALL be ignored and not queued.
REQ-028 Result SHALL equal amt repeated single-bit operations; SHL/SHR of amt=2^AMT_W-1 leaves at most one original bit.

Reset
REQ-029 reset=0 at an edge: state->IDLE, o=0, out_valid=0, busy=0, counter=0, in_ready=1 from that edge, regardless of state.
REQ-030 Reset mid-RUN or mid-DONE SHALL abort the operation with no result delivered.
REQ-031 in_valid during reset SHALL not be accepted.

Verification
REQ-032 op=00 inv=0 amt=4 i0=0x55aa -> o=0x5aa0, out_valid exactly 5 cycles after accept.
REQ-033 op=10 inv=0 amt=1 i0=0x8001 -> o=0x0003 after 2 cycles; op=11 amt=1 i0=0x55aa -> o=0x2ad5.
REQ-034 op=01 inv=1 amt=15 i0=0x0001 (effective SHL) -> o=0x8000 after 16 cycles.
REQ-035 op=01 amt=0 i0=0x7fff -> o=0x7fff, out_valid 1 cycle after accept.
REQ-036 Backpressure: out_ready=0 for 3 cycles in DONE -> o, out_valid stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-037 reset=0 during RUN of op=10 amt=8 i0=0xffff -> next edge o=0, out_valid=0, in_ready=1; no result emitted afterwards.
